// File: rtl/vtim_rx.sv
// vtim_rx: raster timing receiver; measures line/frame geometry once per frame and reports lock.
// Optional grey-ramp pattern checker is built when VTIM_RX_PATCHK_EN is defined.
module vtim_rx #(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12,
    parameter int PW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hs,
    input  logic              vs,
    input  logic              vld,
    input  logic [3*PW-1:0]   rgb,
    output logic [H_BITS-1:0] h_total,
    output logic [H_BITS-1:0] hs_width,
    output logic [H_BITS-1:0] h_act,
    output logic [V_BITS-1:0] v_total,
    output logic [V_BITS-1:0] v_act,
    output logic              meas_vld,
    output logic              locked,
    output logic [15:0]       err_cnt
);

    localparam logic [H_BITS-1:0] H_ONE = H_BITS'(1);
    localparam logic [H_BITS-1:0] H_MAX = '1;
    localparam logic [V_BITS-1:0] V_ONE = V_BITS'(1);
    localparam logic [V_BITS-1:0] V_MAX = '1;

    logic              hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q, vld_s1_q;
    logic              hs_rise, hs_fall, vs_rise;
    logic [H_BITS-1:0] hcnt_q, hcnt_d, actcnt_q, actcnt_d;
    logic [H_BITS-1:0] per_sh_q, per_sh_d, wid_sh_q, wid_sh_d, act_sh_q, act_sh_d;
    logic [V_BITS-1:0] vcnt_q, vcnt_d, vact_cnt_q, vact_cnt_d;
    logic [V_BITS-1:0] v_total_new, v_act_new;
    logic              line_vld_q, line_vld_d;
    logic              armed_q, armed_d, upd_once_q, upd_once_d;
    logic [H_BITS-1:0] h_total_q, h_total_d, hs_width_q, hs_width_d, h_act_q, h_act_d;
    logic [V_BITS-1:0] v_total_q, v_total_d, v_act_q, v_act_d;
    logic              meas_vld_q, meas_vld_d, locked_q, locked_d;

    assign hs_rise = hs_s1_q & ~hs_s2_q;
    assign hs_fall = ~hs_s1_q & hs_s2_q;
    assign vs_rise = vs_s1_q & ~vs_s2_q;

    // Line/frame counters, shadows and measurement outputs.
    always_comb begin
        hcnt_d      = hcnt_q;
        actcnt_d    = actcnt_q;
        per_sh_d    = per_sh_q;
        wid_sh_d    = wid_sh_q;
        act_sh_d    = act_sh_q;
        line_vld_d  = line_vld_q | vld_s1_q;
        vcnt_d      = vcnt_q;
        vact_cnt_d  = vact_cnt_q;
        armed_d     = armed_q;
        upd_once_d  = upd_once_q;
        h_total_d   = h_total_q;
        hs_width_d  = hs_width_q;
        h_act_d     = h_act_q;
        v_total_d   = v_total_q;
        v_act_d     = v_act_q;
        meas_vld_d  = 1'b0;
        locked_d    = locked_q;
        v_total_new = vcnt_q;
        v_act_new   = vact_cnt_q;

        if (hs_rise) begin
            hcnt_d     = H_ONE;
            per_sh_d   = hcnt_q;
            act_sh_d   = actcnt_q;
            actcnt_d   = vld_s1_q ? H_ONE : '0;
            line_vld_d = vld_s1_q;
            if (vcnt_q != V_MAX) begin
                v_total_new = vcnt_q + V_ONE;
            end else begin
                v_total_new = vcnt_q;
            end
            if (line_vld_q && (vact_cnt_q != V_MAX)) begin
                v_act_new = vact_cnt_q + V_ONE;
            end else begin
                v_act_new = vact_cnt_q;
            end
        end else begin
            if (hcnt_q != H_MAX) begin
                hcnt_d = hcnt_q + H_ONE;
            end else begin
                hcnt_d = hcnt_q;
            end
            if (vld_s1_q && (actcnt_q != H_MAX)) begin
                actcnt_d = actcnt_q + H_ONE;
            end else begin
                actcnt_d = actcnt_q;
            end
        end

        if (hs_fall) begin
            wid_sh_d = hcnt_q;
        end else begin
            wid_sh_d = wid_sh_q;
        end

        if (vs_rise) begin
            vcnt_d     = '0;
            vact_cnt_d = '0;
            armed_d    = 1'b1;
            // The first vs rise after reset only opens the measurement window.
            if (armed_q) begin
                h_total_d  = per_sh_q;
                hs_width_d = wid_sh_q;
                h_act_d    = act_sh_q;
                v_total_d  = v_total_new;
                v_act_d    = v_act_new;
                meas_vld_d = 1'b1;
                upd_once_d = 1'b1;
                locked_d   = upd_once_q && (per_sh_q == h_total_q) && (wid_sh_q == hs_width_q)
                             && (act_sh_q == h_act_q) && (v_total_new == v_total_q)
                             && (v_act_new == v_act_q);
            end else begin
                meas_vld_d = 1'b0;
            end
        end else begin
            vcnt_d     = v_total_new;
            vact_cnt_d = v_act_new;
        end

        // A missing hs (line counter saturating) breaks lock immediately.
        if (hcnt_d == H_MAX) begin
            locked_d = 1'b0;
        end else begin
            locked_d = locked_d;
        end
    end

    // Input sampling and all measurement state.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s1_q    <= 1'b0;
            hs_s2_q    <= 1'b0;
            vs_s1_q    <= 1'b0;
            vs_s2_q    <= 1'b0;
            vld_s1_q   <= 1'b0;
            hcnt_q     <= '0;
            actcnt_q   <= '0;
            per_sh_q   <= '0;
            wid_sh_q   <= '0;
            act_sh_q   <= '0;
            line_vld_q <= 1'b0;
            vcnt_q     <= '0;
            vact_cnt_q <= '0;
            armed_q    <= 1'b0;
            upd_once_q <= 1'b0;
            h_total_q  <= '0;
            hs_width_q <= '0;
            h_act_q    <= '0;
            v_total_q  <= '0;
            v_act_q    <= '0;
            meas_vld_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            hs_s1_q    <= hs;
            hs_s2_q    <= hs_s1_q;
            vs_s1_q    <= vs;
            vs_s2_q    <= vs_s1_q;
            vld_s1_q   <= vld;
            hcnt_q     <= hcnt_d;
            actcnt_q   <= actcnt_d;
            per_sh_q   <= per_sh_d;
            wid_sh_q   <= wid_sh_d;
            act_sh_q   <= act_sh_d;
            line_vld_q <= line_vld_d;
            vcnt_q     <= vcnt_d;
            vact_cnt_q <= vact_cnt_d;
            armed_q    <= armed_d;
            upd_once_q <= upd_once_d;
            h_total_q  <= h_total_d;
            hs_width_q <= hs_width_d;
            h_act_q    <= h_act_d;
            v_total_q  <= v_total_d;
            v_act_q    <= v_act_d;
            meas_vld_q <= meas_vld_d;
            locked_q   <= locked_d;
        end
    end

    assign h_total  = h_total_q;
    assign hs_width = hs_width_q;
    assign h_act    = h_act_q;
    assign v_total  = v_total_q;
    assign v_act    = v_act_q;
    assign meas_vld = meas_vld_q;
    assign locked   = locked_q;

`ifdef VTIM_RX_PATCHK_EN
    logic [3*PW-1:0] rgb_s1_q;
    logic [PW-1:0]   exp_q, exp_d, pix_r, pix_g, pix_b;
    logic            synced_q, synced_d;
    logic [15:0]     err_q, err_d;

    assign pix_r = rgb_s1_q[3*PW-1:2*PW];
    assign pix_g = rgb_s1_q[2*PW-1:PW];
    assign pix_b = rgb_s1_q[PW-1:0];

    // Ramp check: exp tracks the next component value; after an error, resync from r.
    always_comb begin
        exp_d    = exp_q;
        synced_d = synced_q;
        err_d    = err_q;
        if (vld_s1_q) begin
            if (!synced_q) begin
                exp_d    = pix_r + PW'(1);
                synced_d = 1'b1;
            end else if ((pix_r == exp_q) && (pix_g == exp_q) && (pix_b == exp_q)) begin
                exp_d = exp_q + PW'(1);
            end else begin
                synced_d = 1'b0;
                if (err_q != 16'hFFFF) begin
                    err_d = err_q + 16'd1;
                end else begin
                    err_d = err_q;
                end
            end
        end else begin
            exp_d = exp_q;
        end
    end

    // Pattern checker state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_s1_q <= '0;
            exp_q    <= '0;
            synced_q <= 1'b0;
            err_q    <= 16'h0000;
        end else begin
            rgb_s1_q <= rgb;
            exp_q    <= exp_d;
            synced_q <= synced_d;
            err_q    <= err_d;
        end
    end

    assign err_cnt = err_q;
`else
    logic unused_rgb;
    assign unused_rgb = ^rgb;
    assign err_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_vtim_rx.sv
// Directed bench for vtim_rx: nominal raster, period change, hs loss, mid-frame reset, pattern error.
module tb_vtim_rx;

    logic        clk = 1'b0;
    logic        rst, hs, vs, vld;
    logic [23:0] rgb;
    logic [11:0] h_total, hs_width, h_act, v_total, v_act;
    logic        meas_vld, locked;
    logic [15:0] err_cnt;

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_upd = 0;
    int          pix   = 0;
    bit          inject = 1'b0;
    logic [11:0] s_ht, s_hw, s_ha, s_vt, s_va;
    logic        s_lk;

`ifdef VTIM_RX_PATCHK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    always #5 clk = ~clk;

    vtim_rx dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb),
        .h_total(h_total), .hs_width(hs_width), .h_act(h_act),
        .v_total(v_total), .v_act(v_act),
        .meas_vld(meas_vld), .locked(locked), .err_cnt(err_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic h, input logic v, input logic a, input logic [23:0] c);
        hs  = h;
        vs  = v;
        vld = a;
        rgb = c;
        @(posedge clk);
        #1;
        if (meas_vld) begin
            n_upd++;
            s_ht = h_total;
            s_hw = hs_width;
            s_ha = h_act;
            s_vt = v_total;
            s_va = v_act;
            s_lk = locked;
        end
    endtask

    // Raster: hs high 10 clocks, vld at 20..83 on lines 4..15, vs high on lines 16..17.
    task automatic frame(input int period, input int nlines);
        logic [7:0]  pv;
        logic [23:0] c;
        logic        a;
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < period; p++) begin
                a = (l >= 4) && (l <= 15) && (p >= 20) && (p < 84);
                c = 24'h000000;
                if (a) begin
                    pv = pix[7:0];
                    c  = {pv, pv, pv};
                    if (inject && (pv == 8'd5)) begin
                        c      = {8'd5, 8'd5, 8'd6};
                        inject = 1'b0;
                    end
                    pix++;
                end
                cyc(p < 10, (l == 16) || (l == 17), a, c);
            end
        end
    endtask

    task automatic check_meas(input string tag, input int ht, input int lk);
        check_val({tag, ".h_total"}, 32'(s_ht), 32'(ht));
        check_val({tag, ".hs_width"}, 32'(s_hw), 32'd10);
        check_val({tag, ".h_act"}, 32'(s_ha), 32'd64);
        check_val({tag, ".v_total"}, 32'(s_vt), 32'd20);
        check_val({tag, ".v_act"}, 32'(s_va), 32'd12);
        check_val({tag, ".locked"}, 32'(s_lk), 32'(lk));
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".h_total"}, 32'(h_total), 32'd0);
        check_val({tag, ".hs_width"}, 32'(hs_width), 32'd0);
        check_val({tag, ".h_act"}, 32'(h_act), 32'd0);
        check_val({tag, ".v_total"}, 32'(v_total), 32'd0);
        check_val({tag, ".v_act"}, 32'(v_act), 32'd0);
        check_val({tag, ".meas_vld"}, 32'(meas_vld), 32'd0);
        check_val({tag, ".locked"}, 32'(locked), 32'd0);
        check_val({tag, ".err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 24'h000000);
        check_zero("reset");
        rst = 1'b0;

        frame(100, 20);
        check_val("first_vs_no_update", 32'(n_upd), 32'd0);
        frame(100, 20);
        check_val("upd1_count", 32'(n_upd), 32'd1);
        check_meas("upd1", 100, 0);
        frame(100, 20);
        check_val("upd2_count", 32'(n_upd), 32'd2);
        check_meas("upd2", 100, 1);
        check_val("upd2.err_cnt", 32'(err_cnt), 32'd0);

        frame(101, 20);
        check_val("upd3_count", 32'(n_upd), 32'd3);
        check_meas("upd3", 101, 0);
        frame(101, 20);
        check_val("upd4_count", 32'(n_upd), 32'd4);
        check_meas("upd4", 101, 1);

        repeat (3900) cyc(1'b0, 1'b0, 1'b0, 24'h000000);
        check_val("hold.locked_before_sat", 32'(locked), 32'd1);
        repeat (300) cyc(1'b0, 1'b0, 1'b0, 24'h000000);
        check_val("hold.hcnt_sat", 32'(dut.hcnt_q), 32'd4095);
        check_val("hold.locked_after_sat", 32'(locked), 32'd0);
        check_val("hold.no_update", 32'(n_upd), 32'd4);
        check_val("hold.h_total_kept", 32'(h_total), 32'd101);

        frame(100, 10);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 24'h000000);
        check_zero("midreset");
        rst = 1'b0;

        frame(100, 20);
        check_val("post_reset_first_vs", 32'(n_upd), 32'd4);
        frame(100, 20);
        check_val("post_reset_upd_count", 32'(n_upd), 32'd5);
        check_meas("post_reset_upd", 100, 0);

        inject = 1'b1;
        frame(100, 20);
        check_val("inject.consumed", 32'(inject), 32'd0);
        check_val("inject.err_cnt", 32'(err_cnt), 32'(EXP_ERR));
        check_meas("inject_upd", 100, 1);
        frame(100, 20);
        check_val("resync.err_cnt", 32'(err_cnt), 32'(EXP_ERR));
        check_val("resync.locked", 32'(locked), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
